// File: rtl/pio_leds_blink.sv
// pio_leds_blink
// Avalon-MM output PIO for the board LED bank. It has a configurable width,
// atomic set/clear/toggle write ports and a blink engine. The blink engine
// periodically masks the selected bits without any CPU involvement.
// The bus side is a zero-wait-state slave with combinational read data.

module pio_leds_blink #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      PRESCALE_W  = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    // Register word addresses
    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
    localparam logic [2:0] ADDR_TOGGLE   = 3'd6;

    // The STATUS word is {cnt, phase}. When PRESCALE_W is 32, that word is
    // one bit wider than the bus, and its top counter bit cannot be read.
    localparam int unsigned STATUS_W = (PRESCALE_W + 1 > 32) ? 32 : PRESCALE_W + 1;

    localparam logic [PRESCALE_W-1:0] ONE_P = PRESCALE_W'(1);

    // Architectural state
    logic [WIDTH-1:0]      data_q,    data_d;
    logic [WIDTH-1:0]      blinkEn_q, blinkEn_d;
    logic [PRESCALE_W-1:0] period_q,  period_d;
    logic [PRESCALE_W-1:0] cnt_q,     cnt_d;
    logic                  phase_q,   phase_d;

    // Bus decode
    logic                  writeEn;
    logic                  wrData;
    logic                  wrBlinkEn;
    logic                  wrPeriod;
    logic                  wrSet;
    logic                  wrClear;
    logic                  wrToggle;
    logic [WIDTH-1:0]      wdWidth;
    logic [PRESCALE_W-1:0] wdPeriod;

    logic [PRESCALE_W-1:0] periodLast;
    logic [PRESCALE_W:0]   statusWide;

    // Writedata bits above the register widths are deliberately dropped.
    // The top STATUS bit is also dropped when it cannot fit on the bus.
    logic unusedBits;
    assign unusedBits = ^{writedata, statusWide};

    // Qualify the write strobe and decode which register it targets.
    always_comb begin
        writeEn   = chipselect & ~write_n;
        wrData    = writeEn && (address == ADDR_DATA);
        wrBlinkEn = writeEn && (address == ADDR_BLINK_EN);
        wrPeriod  = writeEn && (address == ADDR_PERIOD);
        wrSet     = writeEn && (address == ADDR_OUTSET);
        wrClear   = writeEn && (address == ADDR_OUTCLEAR);
        wrToggle  = writeEn && (address == ADDR_TOGGLE);
        wdWidth   = writedata[WIDTH-1:0];
        wdPeriod  = writedata[PRESCALE_W-1:0];
    end

    // DATA next state. Direct writes and the three atomic modify ports are
    // handled here. Only one of these paths can be active in a given cycle.
    always_comb begin
        data_d = data_q;
        if (wrData) begin
            data_d = wdWidth;
        end else if (wrSet) begin
            data_d = data_q | wdWidth;
        end else if (wrClear) begin
            data_d = data_q & ~wdWidth;
        end else if (wrToggle) begin
            data_d = data_q ^ wdWidth;
        end
    end

    // BLINK_EN and PERIOD next state. These are plain load-on-write registers.
    always_comb begin
        blinkEn_d = blinkEn_q;
        period_d  = period_q;
        if (wrBlinkEn) begin
            blinkEn_d = wdWidth;
        end
        if (wrPeriod) begin
            period_d = wdPeriod;
        end
    end

    // Blink engine next state. A PERIOD write restarts the engine, and this
    // takes priority over a rollover that falls due in the same cycle. The >=
    // compare also forces a wrap if PERIOD ever sits below the current count.
    always_comb begin
        periodLast = period_q - ONE_P;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        if (wrPeriod) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (period_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q >= periodLast) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + ONE_P;
        end
    end

    // Register update. Reset is asynchronous, so the LEDs return to
    // RESET_VALUE immediately, without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q    <= RESET_VALUE;
            blinkEn_q <= '0;
            period_q  <= '0;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
        end else begin
            data_q    <= data_d;
            blinkEn_q <= blinkEn_d;
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
        end
    end

    // Read mux. Read data depends only on the address, so it is valid in the
    // same cycle and has no side effects. The write-only ports read as zero.
    always_comb begin
        statusWide = {cnt_q, phase_q};
        readdata   = '0;
        case (address)
            ADDR_DATA:     readdata[WIDTH-1:0]      = data_q;
            ADDR_BLINK_EN: readdata[WIDTH-1:0]      = blinkEn_q;
            ADDR_PERIOD:   readdata[PRESCALE_W-1:0] = period_q;
            ADDR_STATUS:   readdata[STATUS_W-1:0]   = statusWide[STATUS_W-1:0];
            default:       readdata                 = '0;
        endcase
    end

    // LED drive. Blinking bits are forced dark during the odd phase.
    // out_port is built only from registers, so bus activity cannot glitch it.
    always_comb begin
        out_port = data_q & ~(blinkEn_q & {WIDTH{phase_q}});
    end

endmodule

// File: tb/tb_pio_leds_blink.sv
// tb_pio_leds_blink
// Drives two pio_leds_blink instances from a shared bus. The first instance is
// 8 bits wide with RESET_VALUE A5 and a 24-bit prescaler. The second is
// 32 bits wide with a 4-bit prescaler. Each instance is compared against a
// behavioural model that derives the blink state from the number of clocks
// elapsed since the last PERIOD load.

`timescale 1ns/100ps

module tb_pio_leds_blink;

    localparam logic [7:0]  RV0 = 8'hA5;
    localparam logic [31:0] RV1 = 32'hC0DE_0001;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata0;
    logic [31:0] readdata1;
    logic [7:0]  outPort0;
    logic [31:0] outPort1;

    pio_leds_blink #(.WIDTH(8), .RESET_VALUE(RV0), .PRESCALE_W(24)) dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata0), .out_port(outPort0)
    );

    pio_leds_blink #(.WIDTH(32), .RESET_VALUE(RV1), .PRESCALE_W(4)) dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata1), .out_port(outPort1)
    );

    always #10 clk = ~clk;

    // Reference model: register contents plus clocks elapsed since the engine restarted
    logic [31:0] mData [2];
    logic [31:0] mEn   [2];
    logic [31:0] mPer  [2];
    longint      elapsed;
    int          checks = 0;
    int          failures = 0;

    function automatic logic [31:0] widthMask(int k);
        return (k == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] periodMask(int k);
        return (k == 0) ? 32'h00FF_FFFF : 32'h0000_000F;
    endfunction

    function automatic logic [31:0] expCnt(int k);
        if (mPer[k] == 32'h0) return 32'h0;
        return 32'(elapsed % longint'(mPer[k]));
    endfunction

    function automatic logic [31:0] expPhase(int k);
        if (mPer[k] == 32'h0) return 32'h0;
        return 32'((elapsed / longint'(mPer[k])) % 2);
    endfunction

    function automatic logic [31:0] expRead(int k, logic [2:0] a);
        case (a)
            3'd0:    return mData[k];
            3'd1:    return mEn[k];
            3'd2:    return mPer[k];
            3'd3:    return (expCnt(k) << 1) | expPhase(k);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] expOut(int k);
        return mData[k] & ~((expPhase(k) != 0) ? mEn[k] : 32'h0);
    endfunction

    task automatic modelReset();
        mData[0] = {24'h0, RV0};
        mData[1] = RV1;
        for (int k = 0; k < 2; k++) begin
            mEn[k]  = 32'h0;
            mPer[k] = 32'h0;
        end
        elapsed = 0;
    endtask

    task automatic modelEdge(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
        bit periodLoad;
        periodLoad = 1'b0;
        if (cs && !wn) begin
            for (int k = 0; k < 2; k++) begin
                case (a)
                    3'd0: mData[k] = wd & widthMask(k);
                    3'd1: mEn[k]   = wd & widthMask(k);
                    3'd2: mPer[k]  = wd & periodMask(k);
                    3'd4: mData[k] = mData[k] | (wd & widthMask(k));
                    3'd5: mData[k] = mData[k] & ~(wd & widthMask(k));
                    3'd6: mData[k] = mData[k] ^ (wd & widthMask(k));
                    default: ;
                endcase
            end
            periodLoad = (a == 3'd2);
        end
        if (periodLoad) elapsed = 0;
        else            elapsed = elapsed + 1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, " out0"}, {24'h0, outPort0}, expOut(0));
        checkOutput({tag, " out1"}, outPort1, expOut(1));
        checkOutput({tag, " rd0"}, readdata0, expRead(0, address));
        checkOutput({tag, " rd1"}, readdata1, expRead(1, address));
    endtask

    task automatic checkAllReads(input string tag);
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            #1;
            checkOutput($sformatf("%s rd0[%0d]", tag, a), readdata0, expRead(0, 3'(a)));
            checkOutput($sformatf("%s rd1[%0d]", tag, a), readdata1, expRead(1, 3'(a)));
        end
    endtask

    task automatic readCheck(input string tag, input logic [2:0] a, input logic [31:0] exp0, input logic [31:0] exp1);
        address = a;
        #1;
        checkOutput({tag, " rd0"}, readdata0, exp0);
        checkOutput({tag, " rd1"}, readdata1, exp1);
    endtask

    // One bus cycle: drive, clock, update the model, then check away from the edge
    task automatic applyStimulus(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        @(posedge clk);
        modelEdge(cs, wn, a, wd);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'($urandom_range(0, 7));
        #1;
        checkState("cycle");
    endtask

    task automatic busWrite(input logic [2:0] a, input logic [31:0] wd);
        applyStimulus(1'b1, 1'b0, a, wd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b1, 3'($urandom_range(0, 7)), $urandom);
        end
    endtask

    initial begin
        logic        rcs;
        logic        rwn;
        logic [2:0]  ra;
        logic [31:0] rwd;

        modelReset();
        #2 reset = 1'b1;
        #2;
        checkOutput("reset out0", {24'h0, outPort0}, 32'h0000_00A5);
        checkOutput("reset out1", outPort1, RV1);
        checkAllReads("reset");
        #3 reset = 1'b0;

        // DATA and the atomic modify ports
        busWrite(3'd0, 32'hFFFF_FF3C);
        checkOutput("data write", {24'h0, outPort0}, 32'h3C);
        busWrite(3'd4, 32'h41);
        checkOutput("outset", {24'h0, outPort0}, 32'h7D);
        busWrite(3'd5, 32'h0C);
        checkOutput("outclear", {24'h0, outPort0}, 32'h71);
        busWrite(3'd6, 32'hFF);
        checkOutput("toggle", {24'h0, outPort0}, 32'h8E);
        checkOutput("toggle wide", outPort1, 32'hFFFF_FF8E);
        checkAllReads("modify");

        // Blink with PERIOD=4: four cycles at FF, then four cycles at F0
        busWrite(3'd0, 32'hFF);
        busWrite(3'd1, 32'h0F);
        busWrite(3'd2, 32'd4);
        for (int i = 1; i <= 16; i++) begin
            idle(1);
            checkOutput($sformatf("blink4 c%0d", i), {24'h0, outPort0}, (((i / 4) % 2) == 1) ? 32'hF0 : 32'hFF);
        end
        readCheck("blink4 status", 3'd3, expRead(0, 3'd3), expRead(1, 3'd3));

        // Loading PERIOD=0 stops the blink on the next cycle
        busWrite(3'd2, 32'd0);
        checkOutput("period0 out", {24'h0, outPort0}, 32'hFF);
        idle(3);
        readCheck("period0 status", 3'd3, 32'h0, 32'h0);

        // Shortening PERIOD mid-count restarts the engine at the write edge
        busWrite(3'd2, 32'd8);
        idle(3);
        readCheck("p8 cnt3", 3'd3, 32'd6, 32'd6);
        busWrite(3'd2, 32'd2);
        readCheck("p2 restart", 3'd3, 32'd0, 32'd0);
        idle(1);
        readCheck("p2 +1", 3'd3, 32'd2, 32'd2);
        idle(1);
        readCheck("p2 +2", 3'd3, 32'd1, 32'd1);
        checkOutput("p2 toggle", {24'h0, outPort0}, 32'hF0);

        // Oversized PERIOD is truncated; the narrow prescaler wraps at 15
        busWrite(3'd2, 32'hFFFF_FFFF);
        readCheck("period trunc", 3'd2, 32'h00FF_FFFF, 32'h0000_000F);
        idle(14);
        checkOutput("p15 before", outPort1, 32'hFF);
        idle(1);
        checkOutput("p15 toggle", outPort1, 32'hF0);
        idle(15);
        checkOutput("p15 back", outPort1, 32'hFF);
        busWrite(3'd3, 32'h1234_5678);
        busWrite(3'd7, 32'h1234_5678);
        checkAllReads("ro writes");

        // Asynchronous reset in the middle of a blink cycle
        busWrite(3'd2, 32'd3);
        idle(4);
        checkOutput("pre reset", {24'h0, outPort0}, 32'hF0);
        #3 reset = 1'b1;
        #1;
        modelReset();
        checkOutput("async reset out0", {24'h0, outPort0}, 32'h0000_00A5);
        checkOutput("async reset out1", outPort1, RV1);
        checkAllReads("async reset");
        #2 reset = 1'b0;

        // Randomised traffic
        for (int n = 0; n < 800; n++) begin
            rcs = ($urandom_range(0, 3) != 0);
            rwn = ($urandom_range(0, 3) == 0);
            ra  = 3'($urandom_range(0, 7));
            rwd = $urandom;
            if (ra == 3'd2) begin
                rwd = {rwd[31:24], 24'($urandom_range(0, 6))};
            end
            applyStimulus(rcs, rwn, ra, rwd);
        end
        checkAllReads("final");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/pio_leds_blink.md
# pio_leds_blink

Parametrised Avalon-MM output PIO driving the board LED bank from the Nios II system, successor to the fixed 8-bit LED PIO. It adds configurable width, atomic set/clear/toggle write ports and a hardware blink engine. A programmable half-period counter gates selected bits without CPU involvement. The block sits on the system interconnect as a zero-wait-state slave, and its out_port goes directly to the LED pins.

## Interface
- WIDTH, 8: number of output bits, legal range 1..32.
- RESET_VALUE, 0: value loaded into DATA at reset, WIDTH bits.
- PRESCALE_W, 24: width of the PERIOD register and the blink counter, legal range 1..32.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  word address of the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data; bits above the register width are ignored.
- readdata  out  32  combinational read data for the current address, zero-extended.
- out_port  out  WIDTH  LED drive.

## Operation
- A write occurs on any cycle with chipselect=1 and write_n=0.
- Register map, by word address:
  - 0 DATA, RW.
  - 1 BLINK_EN, RW, one enable per output bit.
  - 2 PERIOD, RW, PRESCALE_W bits: blink half-period in clk cycles.
  - 3 STATUS, RO: bit0 = phase, bits[PRESCALE_W:1] = current counter value.
  - 4 OUTSET, WO: DATA <= DATA | writedata.
  - 5 OUTCLEAR, WO: DATA <= DATA & ~writedata.
  - 6 TOGGLE, WO: DATA <= DATA ^ writedata.
  - 7 reserved.
- Reads of addresses 4–7 return 0. Writes to addresses 3 and 7 are ignored.
- readdata depends only on address and current register state, not on chipselect. Reads have no side effects.
- out_port = DATA & ~(BLINK_EN & {WIDTH{phase}}). Blinking bits are forced off while phase=1; non-blinking bits follow DATA.
- Blink engine, when PERIOD = 0:
  - Counter and phase are held at 0.
  - Blink is therefore disabled; out_port = DATA.
- Blink engine, when PERIOD ≠ 0, on each clk:
  - If cnt >= PERIOD-1: cnt <= 0 and phase <= ~phase.
  - Otherwise: cnt <= cnt+1.
  - The >= compare guarantees wrap on the next cycle when PERIOD is reduced below the current cnt.
- A write to PERIOD loads the new value and forces cnt <= 0 and phase <= 0 on the same edge.
  - This overrides any rollover due in that cycle.
- Reset values:
  - DATA = RESET_VALUE.
  - BLINK_EN = 0, PERIOD = 0, cnt = 0, phase = 0.
  - out_port = RESET_VALUE.
  - readdata reflects these values for any address.
- Reset asserted mid-blink returns all state to reset values immediately, with no clock required.

## Timing
- Write latency: a register written at edge N affects out_port and readdata immediately after edge N.
- Reads are zero-wait. readdata is valid in the same cycle address is presented.
- Blink: with PERIOD=P written at edge 0, phase toggles at edges P, 2P, 3P, …
  - The full blink cycle is 2P clocks.
- P=1 toggles every clk.
- Maximum P = 2^PRESCALE_W - 1. The counter never exceeds P-1, so there is no overflow.
- Simultaneous events:
  - A BLINK_EN or DATA write in the same cycle as a phase toggle: both take effect after that edge.
  - Only one bus access per cycle, so set/clear/toggle never collide with each other.
- out_port is a combinational function of registers only, so it is glitch-free relative to bus inputs.

## Test plan
- Reset with RESET_VALUE=8'hA5, WIDTH=8:
  - out_port=A5 and DATA read = 0x000000A5.
  - Addresses 1, 2, 3 read 0.
  - Asserting reset asynchronously mid-cycle clears out_port to A5 without a clk edge.
- Write DATA=0xFFFF_FF3C:
  - out_port=3C and read back = 0x3C.
  - OUTSET 0x41 → 7D; OUTCLEAR 0x0C → 71; TOGGLE 0xFF → 8E.
  - Reads of addresses 4–6 return 0.
- DATA=FF, BLINK_EN=0F, PERIOD=4:
  - out_port alternates FF for 4 cycles, then F0 for 4 cycles, repeating.
  - STATUS bit0 tracks phase; STATUS cnt field runs 0..3.
- During blink, write PERIOD=0:
  - out_port returns to FF on the next cycle.
  - STATUS=0 and stays 0.
- With cnt=3 and PERIOD=8, write PERIOD=2:
  - cnt resets to 0 and phase to 0 at the write edge.
  - The next toggle occurs exactly 2 cycles later.
- WIDTH=32, PRESCALE_W=4:
  - PERIOD write of 0xFFFFFFFF stores 0xF.
  - Phase toggles every 15 cycles.
  - Writing 0x12345678 to STATUS or address 7 changes nothing.
